// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg
// Shared definitions for the reset sequencer: the sequencer state
// encoding, the bit positions inside the sticky reset-cause vector and
// the default timing parameters used by rst_sequencer.
package rst_seq_pkg;

  // Sequencer states in release order; RUN is the only non-busy state.
  typedef enum logic [2:0] {
    ST_ASSERT     = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_REL_MEM    = 3'd2,
    ST_MEM_INIT   = 3'd3,
    ST_REL_PERIPH = 3'd4,
    ST_REL_CORE   = 3'd5,
    ST_RUN        = 3'd6
  } seq_state_t;

  // Bit positions inside the reset-cause vector.
  localparam int CAUSE_W       = 4;
  localparam int CAUSE_POR     = 0;
  localparam int CAUSE_SW      = 1;
  localparam int CAUSE_WDT     = 2;
  localparam int CAUSE_TIMEOUT = 3;

  // Power-on / lock-loss cause value.
  localparam logic [CAUSE_W-1:0] CAUSE_POR_ONLY = 4'b0001;

  // Default timing parameters, in clock cycles.
  localparam int HOLD_CYCLES_DEF  = 6;
  localparam int STAGE_GAP_DEF    = 4;
  localparam int INIT_TIMEOUT_DEF = 1024;

endpackage

// File: rtl/rst_seq_timer.sv
// rst_seq_timer
// Shared up-counter for the reset sequencer. It restarts from zero on
// clear, counts one per cycle and saturates at all-ones instead of
// wrapping. done is high once the counter has spent limit cycles in
// the current phase (count >= limit-1).
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset, loads count with 0
//   clear  in   load count with 0 on the next edge
//   limit  in   phase length in cycles (must be >= 1)
//   done   out  phase length reached, derived from the registered count
module rst_seq_timer #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (count != {W{1'b1}}) begin
      count <= count + W'(1);
    end
  end

  assign done = (count >= (limit - W'(1)));

endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer
// Staged reset release for three domains (memory, peripheral, core).
// After a hold period and a filtered PLL lock, the memory domain is
// released, memory initialisation is kicked off, and the peripheral and
// core domains follow at fixed gaps. In RUN, software or watchdog
// requests restart the sequence; losing lock from REL_MEM onwards
// restarts it as well. All outputs are registered.
//
// Ports:
//   clk_in1          in   clock, rising edge
//   rst              in   synchronous active-high reset
//   pll_locked_i     in   clock-source lock indication
//   sw_rst_req_i     in   software reset request (honoured in RUN only)
//   wdt_rst_req_i    in   watchdog reset request (honoured in RUN only)
//   mem_init_done_i  in   memory initialisation complete
//   mem_init_start_o out  one-cycle pulse starting memory init
//   rst_mem_o        out  memory-domain reset, active high
//   rst_periph_o     out  peripheral-domain reset, active high
//   rst_core_o       out  core-domain reset, active high
//   rst_cause_o      out  sticky cause {timeout, wdt, sw, por/lock-loss}
//   seq_busy_o       out  high whenever the sequencer is not in RUN
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int HOLD_CYCLES  = HOLD_CYCLES_DEF,
  parameter int STAGE_GAP    = STAGE_GAP_DEF,
  parameter int INIT_TIMEOUT = INIT_TIMEOUT_DEF
) (
  input  logic               clk_in1,
  input  logic               rst,
  input  logic               pll_locked_i,
  input  logic               sw_rst_req_i,
  input  logic               wdt_rst_req_i,
  input  logic               mem_init_done_i,
  output logic               mem_init_start_o,
  output logic               rst_mem_o,
  output logic               rst_periph_o,
  output logic               rst_core_o,
  output logic [CAUSE_W-1:0] rst_cause_o,
  output logic               seq_busy_o
);

  localparam int MAX_AB  = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int MAX_ALL = (MAX_AB > INIT_TIMEOUT) ? MAX_AB : INIT_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_ALL) + 1;

  seq_state_t         state;
  seq_state_t         next_state;
  logic               lock_seen;
  logic               lock_seen_next;
  logic [CAUSE_W-1:0] cause_next;
  logic               rst_mem_next;
  logic               rst_periph_next;
  logic               rst_core_next;
  logic               start_next;
  logic               busy_next;
  logic [CNT_W-1:0]   limit;
  logic               timer_clear;
  logic               timer_done;

  // Phase length for the state currently being timed.
  always_comb begin
    limit = CNT_W'(1);
    case (state)
      ST_ASSERT:     limit = CNT_W'(HOLD_CYCLES);
      ST_REL_MEM:    limit = CNT_W'(STAGE_GAP);
      ST_MEM_INIT:   limit = CNT_W'(INIT_TIMEOUT);
      ST_REL_PERIPH: limit = CNT_W'(STAGE_GAP);
      ST_REL_CORE:   limit = CNT_W'(STAGE_GAP);
      default:       limit = CNT_W'(1);
    endcase
  end

  // REL_PERIPH and REL_CORE share one stage gap, so the counter keeps
  // running across that hand-over; every other state change restarts it.
  assign timer_clear = (next_state != state) &&
                       !((state == ST_REL_PERIPH) && (next_state == ST_REL_CORE));

  rst_seq_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk   (clk_in1),
    .rst   (rst),
    .clear (timer_clear),
    .limit (limit),
    .done  (timer_done)
  );

  // Next-state and next-output logic. Lock loss from REL_MEM onwards is
  // applied last so it overrides sw/wdt requests and the init timeout.
  always_comb begin
    next_state     = state;
    lock_seen_next = 1'b0;
    cause_next     = rst_cause_o;

    case (state)
      ST_ASSERT: begin
        if (timer_done) next_state = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        lock_seen_next = pll_locked_i;
        if (pll_locked_i && lock_seen) next_state = ST_REL_MEM;
      end
      ST_REL_MEM: begin
        if (timer_done) next_state = ST_MEM_INIT;
      end
      ST_MEM_INIT: begin
        if (mem_init_done_i) begin
          next_state = ST_REL_PERIPH;
        end else if (timer_done) begin
          next_state                = ST_REL_PERIPH;
          cause_next[CAUSE_TIMEOUT] = 1'b1;
        end
      end
      ST_REL_PERIPH: begin
        // A one-cycle stage gap skips REL_CORE entirely.
        next_state = timer_done ? ST_RUN : ST_REL_CORE;
      end
      ST_REL_CORE: begin
        if (timer_done) next_state = ST_RUN;
      end
      ST_RUN: begin
        if (sw_rst_req_i || wdt_rst_req_i) begin
          next_state            = ST_ASSERT;
          cause_next            = '0;
          cause_next[CAUSE_SW]  = sw_rst_req_i;
          cause_next[CAUSE_WDT] = wdt_rst_req_i;
        end
      end
      default: begin
        next_state = ST_ASSERT;
      end
    endcase

    if (!pll_locked_i &&
        ((state == ST_REL_MEM) || (state == ST_MEM_INIT) ||
         (state == ST_REL_PERIPH) || (state == ST_REL_CORE) ||
         (state == ST_RUN))) begin
      next_state = ST_ASSERT;
      cause_next = CAUSE_POR_ONLY;
    end
  end

  // Outputs follow from the state being entered, which keeps the
  // core/periph/mem release ordering structural.
  always_comb begin
    rst_mem_next    = (next_state == ST_ASSERT) || (next_state == ST_WAIT_LOCK);
    rst_periph_next = rst_mem_next || (next_state == ST_REL_MEM) ||
                      (next_state == ST_MEM_INIT);
    rst_core_next   = (next_state != ST_RUN);
    busy_next       = (next_state != ST_RUN);
    start_next      = (state == ST_REL_MEM) && (next_state == ST_MEM_INIT);
  end

  // State and registered outputs.
  always_ff @(posedge clk_in1) begin
    if (rst) begin
      state            <= ST_ASSERT;
      lock_seen        <= 1'b0;
      rst_mem_o        <= 1'b1;
      rst_periph_o     <= 1'b1;
      rst_core_o       <= 1'b1;
      mem_init_start_o <= 1'b0;
      seq_busy_o       <= 1'b1;
      rst_cause_o      <= CAUSE_POR_ONLY;
    end else begin
      state            <= next_state;
      lock_seen        <= lock_seen_next;
      rst_mem_o        <= rst_mem_next;
      rst_periph_o     <= rst_periph_next;
      rst_core_o       <= rst_core_next;
      mem_init_start_o <= start_next;
      seq_busy_o       <= busy_next;
      rst_cause_o      <= cause_next;
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
`timescale 1ns/1ps
// tb_rst_sequencer
// Directed bench for rst_sequencer with default parameters
// (HOLD_CYCLES=6, STAGE_GAP=4, INIT_TIMEOUT=1024).
module tb_rst_sequencer;

  logic       clk_in1 = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked_i = 1'b1;
  logic       sw_rst_req_i = 1'b0;
  logic       wdt_rst_req_i = 1'b0;
  logic       mem_init_done_i = 1'b0;
  logic       mem_init_start_o;
  logic       rst_mem_o;
  logic       rst_periph_o;
  logic       rst_core_o;
  logic [3:0] rst_cause_o;
  logic       seq_busy_o;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk_in1 = ~clk_in1;

  rst_sequencer dut (
    .clk_in1          (clk_in1),
    .rst              (rst),
    .pll_locked_i     (pll_locked_i),
    .sw_rst_req_i     (sw_rst_req_i),
    .wdt_rst_req_i    (wdt_rst_req_i),
    .mem_init_done_i  (mem_init_done_i),
    .mem_init_start_o (mem_init_start_o),
    .rst_mem_o        (rst_mem_o),
    .rst_periph_o     (rst_periph_o),
    .rst_core_o       (rst_core_o),
    .rst_cause_o      (rst_cause_o),
    .seq_busy_o       (seq_busy_o)
  );

  // One record per clock edge: inputs applied before the edge and the
  // outputs expected just after it.
  typedef struct packed {
    logic       r;
    logic       p;
    logic       s;
    logic       w;
    logic       d;
    logic       mem;
    logic       periph;
    logic       core;
    logic       start;
    logic       busy;
    logic [3:0] cause;
  } vec_t;

  vec_t vecs[$];

  // Drive inputs on the falling edge, then step past the next rising edge.
  task automatic applyStimulus(input logic r, input logic p, input logic s,
                               input logic w, input logic d);
    @(negedge clk_in1);
    rst             = r;
    pll_locked_i    = p;
    sw_rst_req_i    = s;
    wdt_rst_req_i   = w;
    mem_init_done_i = d;
    @(posedge clk_in1);
    #1;
  endtask

  // Compare all registered outputs against the expected bundle.
  task automatic checkOutput(input string name, input logic mem, input logic periph,
                             input logic core, input logic start, input logic busy,
                             input logic [3:0] cause);
    compared++;
    if ({rst_mem_o, rst_periph_o, rst_core_o, mem_init_start_o, seq_busy_o, rst_cause_o}
        !== {mem, periph, core, start, busy, cause}) begin
      mismatched++;
      $display("[TB] FAIL %s: got mem=%b periph=%b core=%b start=%b busy=%b cause=%b, expected mem=%b periph=%b core=%b start=%b busy=%b cause=%b",
               name, rst_mem_o, rst_periph_o, rst_core_o, mem_init_start_o, seq_busy_o,
               rst_cause_o, mem, periph, core, start, busy, cause);
    end
  endtask

  // Compare an edge count against its expected value.
  task automatic checkCount(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d edges, expected %0d", name, actual, expected);
    end
  endtask

  // Push reps identical records.
  task automatic addVec(input int reps, input logic r, input logic p, input logic s,
                        input logic w, input logic d, input logic mem, input logic periph,
                        input logic core, input logic start, input logic busy,
                        input logic [3:0] cause);
    vec_t v;
    v = '{r: r, p: p, s: s, w: w, d: d, mem: mem, periph: periph, core: core,
          start: start, busy: busy, cause: cause};
    repeat (reps) vecs.push_back(v);
  endtask

  // Full release sequence from the edge that entered ASSERT, with init
  // done presented 11 edges after the start pulse edge. With noise set,
  // sw/wdt stay high everywhere outside RUN and must be ignored.
  task automatic addRelease(input logic [3:0] cause, input logic n);
    addVec(7,  0, 1, n, n, 0, 1, 1, 1, 0, 1, cause);
    addVec(4,  0, 1, n, n, 0, 0, 1, 1, 0, 1, cause);
    addVec(1,  0, 1, n, n, 0, 0, 1, 1, 1, 1, cause);
    addVec(10, 0, 1, n, n, 0, 0, 1, 1, 0, 1, cause);
    addVec(1,  0, 1, n, n, 1, 0, 0, 1, 0, 1, cause);
    addVec(3,  0, 1, n, n, 0, 0, 0, 1, 0, 1, cause);
    addVec(1,  0, 1, n, n, 0, 0, 0, 0, 0, 0, cause);
    addVec(3,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0, cause);
  endtask

  // Step with lock p until the start pulse appears; n is the edge count.
  task automatic waitStart(input logic p, input int budget, output int n);
    n = 0;
    do begin
      applyStimulus(0, p, 0, 0, 0);
      n++;
    end while (!mem_init_start_o && n < budget);
    if (!mem_init_start_o) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL wait_start: no start pulse within %0d edges", budget);
    end
  endtask

  initial begin
    int n;
    int bad;

    // Power-on, then sw, sw+wdt (with ignored requests outside RUN), wdt.
    addVec(6, 1, 1, 0, 0, 0, 1, 1, 1, 0, 1, 4'b0001);
    addRelease(4'b0001, 1'b0);
    addVec(1, 0, 1, 1, 0, 0, 1, 1, 1, 0, 1, 4'b0010);
    addRelease(4'b0010, 1'b0);
    addVec(1, 0, 1, 1, 1, 0, 1, 1, 1, 0, 1, 4'b0110);
    addRelease(4'b0110, 1'b1);
    addVec(1, 0, 1, 0, 1, 0, 1, 1, 1, 0, 1, 4'b0100);
    addRelease(4'b0100, 1'b0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].r, vecs[i].p, vecs[i].s, vecs[i].w, vecs[i].d);
      checkOutput($sformatf("vec%0d", i), vecs[i].mem, vecs[i].periph, vecs[i].core,
                  vecs[i].start, vecs[i].busy, vecs[i].cause);
    end

    // Lock loss during MEM_INIT, glitchy relock, then finish to RUN.
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("sw_before_lockloss", 1, 1, 1, 0, 1, 4'b0010);
    waitStart(1, 60, n);
    checkCount("start_latency_sw", n, 12);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("lock_loss_mem_init", 1, 1, 1, 0, 1, 4'b0001);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      if (mem_init_start_o !== 1'b0 || rst_mem_o !== 1'b1) bad++;
    end
    checkCount("unlocked_no_start", bad, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    waitStart(1, 40, n);
    checkCount("relock_restart", n, 6);
    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("periph_after_done", 0, 0, 1, 0, 1, 4'b0001);
    repeat (3) applyStimulus(0, 1, 0, 0, 0);
    checkOutput("core_not_yet", 0, 0, 1, 0, 1, 4'b0001);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("core_release", 0, 0, 0, 0, 0, 4'b0001);

    // Lock loss outranks a software request on the same RUN edge.
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("lock_loss_priority", 1, 1, 1, 0, 1, 4'b0001);

    // Init timeout: periph releases 1024 edges after the start pulse.
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("reset_values", 1, 1, 1, 0, 1, 4'b0001);
    waitStart(1, 60, n);
    checkCount("start_latency_rst", n, 12);
    n = 0;
    do begin
      applyStimulus(0, 1, 0, 0, 0);
      n++;
    end while (rst_periph_o === 1'b1 && n < 1100);
    checkCount("timeout_latency", n, 1024);
    checkOutput("timeout_cause", 0, 0, 1, 0, 1, 4'b1001);
    repeat (4) applyStimulus(0, 1, 0, 0, 0);
    checkOutput("timeout_run", 0, 0, 0, 0, 0, 4'b1001);

    // Done on the timeout edge counts as done; reset clears bit 3.
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("reset_clears_cause", 1, 1, 1, 0, 1, 4'b0001);
    waitStart(1, 60, n);
    repeat (1023) applyStimulus(0, 1, 0, 0, 0);
    checkOutput("before_timeout_edge", 0, 1, 1, 0, 1, 4'b0001);
    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("done_at_timeout", 0, 0, 1, 0, 1, 4'b0001);
    repeat (4) applyStimulus(0, 1, 0, 0, 0);
    checkOutput("done_at_timeout_run", 0, 0, 0, 0, 0, 4'b0001);

    // Reset applied during the peripheral-release stage.
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("sw_before_midrst", 1, 1, 1, 0, 1, 4'b0010);
    waitStart(1, 60, n);
    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("rel_periph_midrst", 0, 0, 1, 0, 1, 4'b0010);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("mid_sequence_reset", 1, 1, 1, 0, 1, 4'b0001);
    repeat (2) applyStimulus(0, 1, 0, 0, 0);
    checkOutput("after_mid_reset", 1, 1, 1, 0, 1, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
